// File: rtl/hex_keypad_scanner_pkg.sv
// Shared types and helpers for the hex keypad scanner: FSM states, idle/reset
// constants, the column-drive pattern and the (column, row) to hex key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] ROW_IDLE  = 4'hF;
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Active-low one-cold drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

  // Index of the lowest active-low row; an idle pattern maps to row 3.
  function automatic logic [1:0] low_row(input logic [3:0] row_s);
    logic [1:0] idx;
    if (!row_s[0]) begin
      idx = 2'd0;
    end else if (!row_s[1]) begin
      idx = 2'd1;
    end else if (!row_s[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] col_idx, input logic [3:0] row_s);
    logic [3:0] code;
    case ({col_idx, low_row(row_s)})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h4;
      4'h2:    code = 4'h7;
      4'h3:    code = 4'h0;
      4'h4:    code = 4'h2;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h8;
      4'h7:    code = 4'hF;
      4'h8:    code = 4'h3;
      4'h9:    code = 4'h6;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hE;
      4'hC:    code = 4'hA;
      4'hD:    code = 4'hB;
      4'hE:    code = 4'hC;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hex_keypad_scanner_sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int           W         = 4,
  parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage capture; the first stage may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: walks the columns, debounces one press per key and
// shifts accepted codes into a 16-bit entry register.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  col,
  input  logic [3:0]  row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] value
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_SCANS);
  localparam bit            DEB_ONE    = (DEBOUNCE_SCANS == 1);

  logic [3:0]    row_s;
  logic [TW-1:0] tick_r;
  logic [1:0]    col_idx_r;
  logic [DW-1:0] deb_r;
  logic [DW-1:0] rel_r;
  logic [3:0]    cand_r;
  logic [3:0]    pat_r;
  state_t        state_r;

  logic          sample_s;
  logic [1:0]    next_idx_s;
  logic [3:0]    code_s;

  sync2 #(
    .W         (4),
    .RESET_VAL (ROW_IDLE)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_s)
  );

  assign sample_s   = (tick_r == TICK_LAST);
  assign next_idx_s = col_idx_r + 2'd1;
  assign code_s     = key_map(col_idx_r, row_s);

  // Scan timing, debounce/release FSM and registered keypad outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r    <= {TW{1'b0}};
      col_idx_r <= 2'd0;
      col       <= COL_RESET;
      deb_r     <= {DW{1'b0}};
      rel_r     <= {DW{1'b0}};
      cand_r    <= 4'h0;
      pat_r     <= ROW_IDLE;
      state_r   <= SCAN;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      value     <= 16'h0000;
    end else begin
      key_valid <= 1'b0;
      if (sample_s) begin
        tick_r <= {TW{1'b0}};
      end else begin
        tick_r <= tick_r + TW'(1);
      end

      if (sample_s) begin
        case (state_r)
          SCAN: begin
            if (row_s == ROW_IDLE) begin
              col_idx_r <= next_idx_s;
              col       <= col_drive(next_idx_s);
            end else if (DEB_ONE) begin
              cand_r    <= code_s;
              pat_r     <= row_s;
              key_valid <= 1'b1;
              key_code  <= code_s;
              value     <= {value[11:0], code_s};
              rel_r     <= {DW{1'b0}};
              state_r   <= HELD;
            end else begin
              cand_r  <= code_s;
              pat_r   <= row_s;
              deb_r   <= DW'(1);
              state_r <= DEBOUNCE;
            end
          end

          DEBOUNCE: begin
            if (row_s == pat_r) begin
              if ((deb_r + DW'(1)) == DEB_TARGET) begin
                key_valid <= 1'b1;
                key_code  <= cand_r;
                value     <= {value[11:0], cand_r};
                deb_r     <= {DW{1'b0}};
                rel_r     <= {DW{1'b0}};
                state_r   <= HELD;
              end else begin
                deb_r <= deb_r + DW'(1);
              end
            end else begin
              // Bounce or a different row: drop the candidate silently.
              deb_r     <= {DW{1'b0}};
              col_idx_r <= next_idx_s;
              col       <= col_drive(next_idx_s);
              state_r   <= SCAN;
            end
          end

          HELD: begin
            if (row_s == ROW_IDLE) begin
              if ((rel_r + DW'(1)) == DEB_TARGET) begin
                rel_r     <= {DW{1'b0}};
                col_idx_r <= next_idx_s;
                col       <= col_drive(next_idx_s);
                state_r   <= SCAN;
              end else begin
                rel_r <= rel_r + DW'(1);
              end
            end else begin
              rel_r <= {DW{1'b0}};
            end
          end

          default: begin
            deb_r   <= {DW{1'b0}};
            rel_r   <= {DW{1'b0}};
            state_r <= SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner with a behavioural 4x4 keypad.
module tb_hex_keypad_scanner;

  localparam int ST = 4;
  localparam int DS = 3;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] value;

  logic [15:0] pressed;
  logic [15:0] exp_val;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hex_keypad_scanner #(
    .SCAN_TICKS     (ST),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .value     (value)
  );

  // Keypad: row r pulled low when key (r,c) is down and column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] code);
    exp_t e;
    exp_val = {exp_val[11:0], code};
    e.code  = code;
    e.val   = exp_val;
    exp_q.push_back(e);
  endtask

  task automatic press_key(input int r, input int c, input logic [3:0] code);
    pressed[r*4+c] = 1'b1;
    push_exp(code);
    repeat (40) @(negedge clk);
    pressed[r*4+c] = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  // Returns at the first negedge on which col newly equals target.
  task automatic wait_col(input logic [3:0] target);
    int n;
    n = 0;
    while ((col == target) && (n < 64)) begin
      @(negedge clk);
      n++;
    end
    while ((col != target) && (n < 128)) begin
      @(negedge clk);
      n++;
    end
    if (col != target) begin
      checks++;
      errors++;
      $display("FAIL wait_col timeout actual=%h required=%h", col, target);
    end
  endtask

  // Monitor: every key_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if ((rst === 1'b0) && (key_valid === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual code=%h required no pulse", key_code);
      end else begin
        mon_e = exp_q.pop_front();
        check("key_code", {12'h000, key_code}, {12'h000, mon_e.code});
        check("value", value, mon_e.val);
      end
    end
  end

  initial begin
    logic [3:0] ec;
    int first_j;
    int n;
    rst     = 1'b1;
    pressed = 16'h0000;
    exp_val = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_col", {12'h000, col}, 16'h000E);
    check("rst_key_valid", {15'h0000, key_valid}, 16'h0000);
    check("rst_key_code", {12'h000, key_code}, 16'h0000);
    check("rst_value", value, 16'h0000);
    rst = 1'b0;

    // Idle scan: column index advances every ST cycles.
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      ec = ~(4'b0001 << ((k / ST) % 4));
      check("idle_col", {12'h000, col}, {12'h000, ec});
    end
    check("idle_value", value, 16'h0000);

    // Key 5 with exact latency: col1 driven at +4, sampled at +8, accept at +16.
    pressed[1*4+1] = 1'b1;
    push_exp(4'h5);
    first_j = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if ((first_j == 0) && (key_valid === 1'b1)) first_j = j;
    end
    check("latency5", 16'(first_j), 16'd16);
    check("held5_col", {12'h000, col}, 16'h000D);
    pressed[1*4+1] = 1'b0;
    repeat (4) @(negedge clk);
    check("release5_col", {12'h000, col}, 16'h000D);
    repeat (30) @(negedge clk);

    press_key(0, 0, 4'h1);
    press_key(0, 3, 4'hA);
    press_key(3, 1, 4'hF);
    press_key(3, 0, 4'h0);
    check("seq_value", value, 16'h1AF0);
    check("seq_key_code", {12'h000, key_code}, 16'h0000);

    // Bounce on 9: one-sample contact, one-sample release, then steady press.
    wait_col(4'b1011);
    pressed[2*4+2] = 1'b1;
    push_exp(4'h9);
    repeat (4) @(negedge clk);
    pressed[2*4+2] = 1'b0;
    repeat (4) @(negedge clk);
    pressed[2*4+2] = 1'b1;
    repeat (40) @(negedge clk);
    pressed[2*4+2] = 1'b0;
    repeat (30) @(negedge clk);

    // 4 and 7 together: lowest row wins.
    pressed[1*4+0] = 1'b1;
    pressed[2*4+0] = 1'b1;
    push_exp(4'h4);
    repeat (40) @(negedge clk);
    pressed[1*4+0] = 1'b0;
    pressed[2*4+0] = 1'b0;
    repeat (30) @(negedge clk);

    // 2 pressed while 8 is held: no additional pulse.
    pressed[2*4+1] = 1'b1;
    push_exp(4'h8);
    repeat (40) @(negedge clk);
    pressed[0*4+1] = 1'b1;
    repeat (20) @(negedge clk);
    check("held8_col", {12'h000, col}, 16'h000D);
    pressed[0*4+1] = 1'b0;
    pressed[2*4+1] = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_rst_value", value, 16'h0948);

    // Reset during debounce of C.
    wait_col(4'b0111);
    pressed[2*4+3] = 1'b1;
    repeat (6) @(negedge clk);
    rst     = 1'b1;
    pressed = 16'h0000;
    @(negedge clk);
    check("mid_rst_col", {12'h000, col}, 16'h000E);
    check("mid_rst_value", value, 16'h0000);
    check("mid_rst_key_valid", {15'h0000, key_valid}, 16'h0000);
    rst     = 1'b0;
    exp_val = 16'h0000;
    repeat (20) @(negedge clk);
    press_key(2, 3, 4'hC);
    check("final_value", value, 16'h000C);

    n = 0;
    while ((exp_q.size() != 0) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("pending_expected", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
